// File: rtl/nora_pkg.sv
// Shared NORA definitions: FSM state encoding for the pushbutton reader.
package nora_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous pin.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages come out of reset at the idle pin level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Debounced pushbutton reader: synchronizes the raw pin, filters it with a
// down-counting debounce window and emits a clean level plus press, release,
// short-press and long-press pulses.
module button_debounce
    import nora_pkg::*;
#(
    parameter logic             BTN_ACTIVE   = 1'b0,
    parameter logic [CNT_W-1:0] DEBOUNCE_TOP = 32'h0000FFFF,
    parameter logic [CNT_W-1:0] LONG_TOP     = 32'h00FFFFFF
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o
);

    logic             sync_q;
    logic             btn_s;
    btn_state_e       state;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             long_seen;
    logic             long_fire;

    // The synchronizer ignores enable so the pin is already settled when the
    // reader is re-enabled.
    sync_2ff #(
        .RESET_VAL(~BTN_ACTIVE)
    ) u_sync (
        .clk   (clk),
        .resetn(resetn),
        .d     (btn_i),
        .q     (sync_q)
    );

    assign btn_s = (sync_q == BTN_ACTIVE);

    // Hold timer has expired and no long pulse was issued yet for this press.
    assign long_fire = !long_seen && (hold_cnt == '0);

    // Debounce FSM with registered one-cycle event pulses.
    always_ff @(posedge clk) begin
        press_o   <= 1'b0;
        release_o <= 1'b0;
        short_o   <= 1'b0;
        long_o    <= 1'b0;
        if (!resetn || !enable) begin
            // Forced idle: level drops silently, no release pulse.
            state     <= ST_IDLE;
            deb_cnt   <= DEBOUNCE_TOP;
            hold_cnt  <= LONG_TOP;
            long_seen <= 1'b0;
            level_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_s) begin
                        state   <= ST_PRESS_WAIT;
                        deb_cnt <= DEBOUNCE_TOP;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= ST_IDLE;
                    end else if (deb_cnt == '0) begin
                        state     <= ST_HELD;
                        level_o   <= 1'b1;
                        press_o   <= 1'b1;
                        hold_cnt  <= LONG_TOP;
                        long_seen <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt - 1'b1;
                    end
                end
                ST_HELD: begin
                    // Leaving for the release window takes priority over the
                    // hold timer for this one cycle.
                    if (!btn_s) begin
                        state   <= ST_RELEASE_WAIT;
                        deb_cnt <= DEBOUNCE_TOP;
                    end else if (long_fire) begin
                        long_o    <= 1'b1;
                        long_seen <= 1'b1;
                    end else if (!long_seen) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A release that is still bouncing is still a hold.
                    if (long_fire) begin
                        long_o    <= 1'b1;
                        long_seen <= 1'b1;
                    end else if (!long_seen) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                    if (btn_s) begin
                        state   <= ST_HELD;
                        deb_cnt <= DEBOUNCE_TOP;
                    end else if (deb_cnt == '0) begin
                        state     <= ST_IDLE;
                        level_o   <= 1'b0;
                        release_o <= 1'b1;
                        // A long pulse issued in this same cycle still
                        // suppresses the short pulse.
                        short_o   <= !(long_seen || long_fire);
                    end else begin
                        deb_cnt <= deb_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenario table, hand-written corner
// sequences and randomized pin activity, all checked every cycle against a
// run-length reference model.
module tb_button_debounce;

    localparam logic        BTN_ACTIVE = 1'b0;
    localparam logic [31:0] DT         = 32'd4;
    localparam logic [31:0] LT         = 32'd20;
    localparam logic        PRS        = BTN_ACTIVE;
    localparam logic        REL        = ~BTN_ACTIVE;

    logic clk = 1'b0;
    logic resetn, enable, btn_i;
    logic level_o, press_o, release_o, short_o, long_o;

    button_debounce #(
        .BTN_ACTIVE  (BTN_ACTIVE),
        .DEBOUNCE_TOP(DT),
        .LONG_TOP    (LT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .btn_i    (btn_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .short_o  (short_o),
        .long_o   (long_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_press = 0, n_rel = 0, n_long = 0, n_short = 0;
    int last_press = -1, last_rel = -1, last_long = -1;
    logic rel_short = 1'b0;

    // Reference model: pin history in a 2-deep delay line, acceptance by
    // counting consecutive stable cycles upward, hold measured as an age.
    bit m_s1, m_s2, m_level, m_pending, m_long_done;
    int m_run, m_age;
    bit m_press, m_rel, m_short, m_long;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_level = 0; m_pending = 0; m_run = 0; m_age = 0; m_long_done = 0;
    endtask

    task automatic model_step(input logic b, input logic en, input logic rn);
        bit s, ticking;
        m_press = 0; m_rel = 0; m_short = 0; m_long = 0;
        if (!rn) begin
            m_s1 = 0; m_s2 = 0;
            model_clear();
            return;
        end
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = (b == BTN_ACTIVE);
        if (!en) begin
            model_clear();
            return;
        end
        if (!m_level) begin
            if (!m_pending) begin
                if (s) begin m_pending = 1; m_run = 0; end
            end else if (!s) begin
                m_pending = 0;
            end else if (m_run == int'(DT)) begin
                m_level = 1; m_press = 1; m_age = 0; m_long_done = 0; m_pending = 0;
            end else begin
                m_run++;
            end
        end else begin
            // Hold time advances while held, and throughout a release window,
            // but not on the cycle the release is first seen.
            ticking = m_pending || s;
            if (ticking && !m_long_done) begin
                if (m_age == int'(LT)) begin m_long = 1; m_long_done = 1; end
                else m_age++;
            end
            if (!m_pending) begin
                if (!s) begin m_pending = 1; m_run = 0; end
            end else if (s) begin
                m_pending = 0;
            end else if (m_run == int'(DT)) begin
                m_level = 0; m_rel = 1; m_short = !m_long_done; m_pending = 0;
            end else begin
                m_run++;
            end
        end
    endtask

    // One clock: drive, step the model, sample 1 time unit after the edge.
    task automatic tick(input logic b, input logic en, input logic rn);
        btn_i = b; enable = en; resetn = rn;
        @(posedge clk);
        model_step(b, en, rn);
        #1;
        cyc++;
        check("model_outputs", int'({level_o, press_o, release_o, short_o, long_o}),
              int'({m_level, m_press, m_rel, m_short, m_long}));
        if (press_o === 1'b1)   begin n_press++; last_press = cyc; end
        if (release_o === 1'b1) begin n_rel++; last_rel = cyc; rel_short = short_o; end
        if (long_o === 1'b1)    begin n_long++; last_long = cyc; end
        if (short_o === 1'b1)   n_short++;
    endtask

    // Hold the pin pressed until press_o; dly counts from the first tick.
    task automatic press_wait(input logic en, output int dly);
        int start, p0;
        start = cyc + 1;
        p0    = n_press;
        for (int i = 0; i < 40 && n_press == p0; i++) tick(PRS, en, 1'b1);
        dly = (n_press == p0) ? -1 : last_press - start;
    endtask

    task automatic go_idle();
        for (int i = 0; i < 60 && level_o !== 1'b0; i++) tick(REL, 1'b1, 1'b1);
        repeat (4) tick(REL, 1'b1, 1'b1);
    endtask

    typedef struct {
        int hold;      // ticks held after press_o before the pin is released
        int exp_long;
        int long_dly;  // press_o to long_o, in cycles
        int exp_short;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int dly, p, l0, r0, s0, h;
        logic b;
        int seg;

        // Release at h ticks after press: release_o at press+h+8. The hold
        // timer loses the one cycle where the release is first seen, so a
        // long pulse landing in the release window comes at press+22.
        tbl[0] = '{10,  0, 0,  1};
        tbl[1] = '{13,  0, 0,  1};
        tbl[2] = '{14,  1, 22, 0};  // long_o and release_o in the same cycle
        tbl[3] = '{18,  1, 22, 0};
        tbl[4] = '{19,  1, 21, 0};
        tbl[5] = '{100, 1, 21, 0};

        btn_i = REL; enable = 1'b1; resetn = 1'b0;

        // Reset held with the button pressed: everything stays 0.
        repeat (3) begin
            tick(PRS, 1'b1, 1'b0);
            check("reset_outputs", int'({level_o, press_o, release_o, short_o, long_o}), 0);
        end
        press_wait(1'b1, dly);
        check("reset_release_press_dly", dly, 7);
        check("reset_release_level", int'(level_o), 1);
        go_idle();

        // Press/hold/release scenarios.
        foreach (tbl[k]) begin
            press_wait(1'b1, dly);
            check("tbl_press_dly", dly, 7);
            p  = last_press;
            l0 = n_long;
            r0 = n_rel;
            repeat (tbl[k].hold) tick(PRS, 1'b1, 1'b1);
            for (int i = 0; i < 40 && n_rel == r0; i++) tick(REL, 1'b1, 1'b1);
            check("tbl_release_dly", last_rel - p, tbl[k].hold + 8);
            check("tbl_long_count", n_long - l0, tbl[k].exp_long);
            if (tbl[k].exp_long != 0) check("tbl_long_dly", last_long - p, tbl[k].long_dly);
            check("tbl_short", int'(rel_short), tbl[k].exp_short);
            go_idle();
        end

        // Short glitch: never accepted.
        p = n_press;
        repeat (3) tick(PRS, 1'b1, 1'b1);
        repeat (20) tick(REL, 1'b1, 1'b1);
        check("glitch_no_press", n_press - p, 0);
        check("glitch_level", int'(level_o), 0);

        // Press-side bounce 0,1,0,0...: window restarts on the final 0.
        tick(PRS, 1'b1, 1'b1);
        tick(REL, 1'b1, 1'b1);
        press_wait(1'b1, dly);
        check("bounce_press_dly", dly, 7);

        // Release bounce: two inactive ticks, then pressed again.
        p  = last_press;
        r0 = n_rel;
        l0 = n_long;
        repeat (2) tick(PRS, 1'b1, 1'b1);
        repeat (2) tick(REL, 1'b1, 1'b1);
        repeat (30) tick(PRS, 1'b1, 1'b1);
        check("relbounce_no_release", n_rel - r0, 0);
        check("relbounce_level", int'(level_o), 1);
        check("relbounce_long_count", n_long - l0, 1);
        check("relbounce_long_dly", last_long - p, int'(LT) + 2);
        go_idle();

        // Enable drop while held, then re-enable with the pin still pressed.
        press_wait(1'b1, dly);
        repeat (3) tick(PRS, 1'b1, 1'b1);
        r0 = n_rel;
        s0 = n_short;
        tick(PRS, 1'b0, 1'b1);
        check("endrop_level", int'(level_o), 0);
        repeat (4) tick(PRS, 1'b0, 1'b1);
        check("endrop_no_release", n_rel - r0, 0);
        check("endrop_no_short", n_short - s0, 0);
        press_wait(1'b1, dly);
        check("reenable_press_dly", dly, 5);

        // Reset mid-press: level drops with no release pulse.
        r0 = n_rel;
        tick(PRS, 1'b1, 1'b0);
        check("midreset_level", int'(level_o), 0);
        check("midreset_no_release", n_rel - r0, 0);
        go_idle();

        // Randomized pin activity with occasional enable drops and resets.
        for (int n = 0; n < 300; n++) begin
            b   = $urandom_range(0, 1) ? PRS : REL;
            seg = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 60);
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(1, 3)) tick(b, 1'b1, 1'b0);
            end else if ($urandom_range(0, 19) == 0) begin
                repeat (seg) tick(b, 1'b0, 1'b1);
            end else begin
                repeat (seg) tick(b, 1'b1, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
